c4_win_checker: RTL
===================

# c4_win_checker

Downstream win-detection stage for the Connect 4 game logic. It consumes one accepted-placement event per move (row, column, player) from the board/placement logic and keeps its own shadow copy of the 6x7 board. After each move it scans the four line directions through the new piece and reports win, winner, or draw back to the turn FSM. Latency is fixed and deterministic.

## Interface
- ROWS, 6, board rows; row 0 is the top row and row 5 the bottom; cell index = row*7 + col
- COLS, 7, board columns
- CLOCK_50  in  1  system clock
- Resetn  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous new-game clear; same effect as reset; has priority over place_valid
- place_valid  in  1  one-cycle pulse; a piece has been accepted at place_row/place_col
- place_row  in  3  row of the placed piece (0..5)
- place_col  in  3  column of the placed piece (0..6)
- place_player  in  2  01 = P1, 10 = P2
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when the scan result is valid
- win  out  1  sticky; a four-in-line exists
- winner  out  2  player that won; 00 until win
- draw  out  1  sticky; 42 pieces placed with no win
- pieces  out  6  number of accepted pieces
- err_overrun  out  1  sticky; place_valid arrived while busy
- err_bad  out  1  sticky; malformed or illegal placement was rejected

## Operation
- Shadow board: 42 x 2-bit cells, 00 = empty. All cells clear on reset or clr.
- Placement acceptance, in IDLE only. The placement is rejected when any of these holds:
  - place_row > 5 or place_col > 6
  - place_player is not 01 or 10
  - the target cell is non-empty
  - win or draw is already set
- Rejected placement: err_bad is set. There is no board write, no scan, and no done. The one exception: a placement after win or draw is silently ignored, and err_bad is not set.
- Accepted placement: the cell is written, pieces increments, the coordinates and player are latched, and the state moves to SCAN.
- place_valid while busy: ignored and err_overrun is set. The scan in progress is unaffected.
- FSM states are IDLE, SCAN and DONE.
  - IDLE goes to SCAN on an accepted placement.
  - SCAN runs a 24-step probe counter (0..23). It goes to DONE after probe 23.
  - DONE lasts exactly one cycle, then returns to IDLE.
- Probe order: 4 directions, each with 3 probes on the + side followed by 3 on the - side.
  - d0 = (0,+1) horizontal
  - d1 = (+1,0) vertical
  - d2 = (+1,+1) diagonal
  - d3 = (+1,-1) anti-diagonal
  - Probe k (1..3) examines (row ± k*dr, col ± k*dc).
- Run counting, per direction:
  - count (3 bits) starts at 1; there is one alive flag per side, starting at 1.
  - A probe counts only while its side is alive. If the cell is in bounds and equals the latched player, count increments; otherwise that side's alive flag goes to 0.
  - Bounds are checked with signed 4-bit arithmetic. An out-of-range probe counts as a mismatch.
  - Maximum count is 7.
  - At the end of the direction, hit is set if count >= 4.
- In DONE:
  - If any direction hit: win = 1 and winner = latched player.
  - Else if pieces == 42: draw = 1.
  - done is asserted.

## Timing
- Reset and clr values: every output is 0, winner is 00, the FSM is in IDLE, and the board is empty.
- Let E0 be the clock edge that samples an accepted place_valid.
- busy is high from E0 until E25 and low after E25.
- win, winner, draw, and the done pulse all update at E25. done is high for exactly one cycle. With no stalls, latency is fixed at 25 cycles.
- The next place_valid is accepted from E25 onward. This includes the DONE cycle: a placement sampled at E26 is accepted.
- Resetn asserted mid-scan aborts immediately: all state clears and no done is produced. clr mid-scan behaves the same on the next edge.
- Simultaneous clr and place_valid: clr wins and the placement is discarded.
- Sticky flags (win, draw, err_overrun, err_bad) clear only on reset or clr.

## Test plan
- Horizontal win: P1 at (5,0), (5,1), (5,2), then (5,3). The first three moves give done with win = 0. The fourth gives win = 1 and winner = 01 exactly 25 cycles after its place_valid.
- Vertical, diagonal, and edge cases for P2:
  - (5,6), (4,6), (3,6), (2,6) gives winner = 10 on the fourth move.
  - Diagonal (5,0), (4,1), (3,2), (2,3) gives a win.
  - Three-in-line touching the board edge, e.g. (0,4), (0,5), (0,6), gives no win.
- Middle insertion: P1 at (5,0), (5,1), (5,3), then (5,2). This gives win = 1, proving both sides are summed (count = 4).
- Errors:
  - place_col = 7 sets err_bad and pieces does not change.
  - Placing into an occupied cell sets err_bad.
  - A second place_valid 5 cycles after an accepted one sets err_overrun, and the first scan still gives done at E25.
- Draw: a 42-move fill with no four-in-line gives draw = 1 and pieces = 42 on the last done. A 43rd place_valid leaves all outputs unchanged.
- Reset and clr:
  - Resetn pulsed at E10 of a scan: busy = 0 immediately, no done pulse, the board is empty, and the next move scans normally.
  - clr after a win returns win to 0 and winner to 00.

Source files
------------

// File: rtl/c4_win_checker.sv
// Connect 4 win/draw detector: keeps a shadow board and, after each accepted move,
// walks the four line directions through the new piece over a fixed 24-probe scan.
module c4_win_checker #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       clr,
    input  logic       place_valid,
    input  logic [2:0] place_row,
    input  logic [2:0] place_col,
    input  logic [1:0] place_player,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic [1:0] winner,
    output logic       draw,
    output logic [5:0] pieces,
    output logic       err_overrun,
    output logic       err_bad
);
    localparam int              CELLS  = ROWS * COLS;
    localparam logic signed [3:0] ROWS_S = 4'(ROWS);
    localparam logic signed [3:0] COLS_S = 4'(COLS);
    localparam logic [5:0]      COLS_U = 6'(COLS);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0] board [CELLS];
    logic [2:0] row_q, col_q;
    logic [1:0] player_q;
    logic [1:0] dir_q;
    logic [2:0] step_q;
    logic [2:0] count_q;
    logic       alive_pos, alive_neg, hit_q;

    logic       fmt_ok, target_occ, game_over, accept, reject;
    logic [5:0] place_idx;

    always_comb begin
        fmt_ok     = (place_row < 3'(ROWS)) && (place_col < 3'(COLS)) &&
                     (place_player == 2'b01 || place_player == 2'b10);
        place_idx  = 6'(place_row) * COLS_U + 6'(place_col);
        target_occ = fmt_ok && (board[place_idx] != 2'b00);
        game_over  = win | draw;
        accept     = (state == IDLE) && place_valid && !game_over && fmt_ok && !target_occ;
        reject     = (state == IDLE) && place_valid && !game_over && !(fmt_ok && !target_occ);
    end

    // Probe address: steps 0..2 walk the + side, 3..5 the - side, distance 1..3.
    // Coordinates are 4-bit signed so off-board probes show up as negative or too large.
    logic              neg_side, in_bounds, match, side_alive;
    logic [1:0]        k;
    logic signed [3:0] dr, dc, pr, pc;
    logic [5:0]        probe_idx;
    logic [2:0]        cnt_nxt;

    always_comb begin
        neg_side = (step_q >= 3'd3);
        k        = neg_side ? 2'(step_q - 3'd2) : 2'(step_q + 3'd1);
        case (dir_q)
            2'd0:    begin dr = 4'sd0; dc = 4'sd1;  end
            2'd1:    begin dr = 4'sd1; dc = 4'sd0;  end
            2'd2:    begin dr = 4'sd1; dc = 4'sd1;  end
            default: begin dr = 4'sd1; dc = -4'sd1; end
        endcase
        if (neg_side) begin
            dr = -dr;
            dc = -dc;
        end
        pr         = $signed({1'b0, row_q}) + $signed({2'b00, k}) * dr;
        pc         = $signed({1'b0, col_q}) + $signed({2'b00, k}) * dc;
        in_bounds  = !pr[3] && (pr < ROWS_S) && !pc[3] && (pc < COLS_S);
        probe_idx  = 6'(pr[2:0]) * COLS_U + 6'(pc[2:0]);
        match      = in_bounds && (board[probe_idx] == player_q);
        side_alive = neg_side ? alive_neg : alive_pos;
        cnt_nxt    = count_q + 3'(side_alive && match);
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (dir_q == 2'd3 && step_q == 3'd5) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr)
            state_nxt = IDLE;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < CELLS; i++) board[i] <= 2'b00;
        end else if (clr) begin
            for (int i = 0; i < CELLS; i++) board[i] <= 2'b00;
        end else if (accept) begin
            board[place_idx] <= place_player;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            done <= 1'b0;  win <= 1'b0;  winner <= 2'b00;  draw <= 1'b0;
            pieces <= '0;  err_overrun <= 1'b0;  err_bad <= 1'b0;
            row_q <= '0;  col_q <= '0;  player_q <= '0;
            dir_q <= '0;  step_q <= '0;  count_q <= 3'd1;
            alive_pos <= 1'b1;  alive_neg <= 1'b1;  hit_q <= 1'b0;
        end else if (clr) begin
            done <= 1'b0;  win <= 1'b0;  winner <= 2'b00;  draw <= 1'b0;
            pieces <= '0;  err_overrun <= 1'b0;  err_bad <= 1'b0;
            row_q <= '0;  col_q <= '0;  player_q <= '0;
            dir_q <= '0;  step_q <= '0;  count_q <= 3'd1;
            alive_pos <= 1'b1;  alive_neg <= 1'b1;  hit_q <= 1'b0;
        end else begin
            done <= 1'b0;
            if (place_valid && state != IDLE)
                err_overrun <= 1'b1;
            if (reject)
                err_bad <= 1'b1;
            if (accept) begin
                row_q     <= place_row;
                col_q     <= place_col;
                player_q  <= place_player;
                pieces    <= pieces + 6'd1;
                dir_q     <= '0;
                step_q    <= '0;
                count_q   <= 3'd1;
                alive_pos <= 1'b1;
                alive_neg <= 1'b1;
                hit_q     <= 1'b0;
            end
            if (state == SCAN) begin
                if (side_alive && !match) begin
                    if (neg_side) alive_neg <= 1'b0;
                    else          alive_pos <= 1'b0;
                end
                // Last probe of a direction: fold its run into hit and rearm for the next one.
                if (step_q == 3'd5) begin
                    hit_q     <= hit_q | (cnt_nxt >= 3'd4);
                    count_q   <= 3'd1;
                    alive_pos <= 1'b1;
                    alive_neg <= 1'b1;
                    step_q    <= '0;
                    dir_q     <= dir_q + 2'd1;
                end else begin
                    count_q <= cnt_nxt;
                    step_q  <= step_q + 3'd1;
                end
            end
            if (state == DONE) begin
                done  <= 1'b1;
                hit_q <= 1'b0;
                if (hit_q) begin
                    win    <= 1'b1;
                    winner <= player_q;
                end else if (pieces == 6'(CELLS)) begin
                    draw <= 1'b1;
                end
            end
        end
    end
endmodule
